// File: rtl/norm_pkg.sv
// Shared types and constants for the shift normaliser and its stop detector.
package norm_pkg;

    localparam int unsigned NORM_WIDTH = 16;
    localparam int unsigned NORM_CNT_W = 4;

    localparam logic NORM_UNSIGNED = 1'b0;
    localparam logic NORM_SIGNED   = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } norm_state_e;

endpackage

// File: rtl/norm_stop_detect.sv
// Combinational stop test for the normaliser: true once the working value is
// normalised, zero, or the shift count has reached its cap.
module norm_stop_detect
    import norm_pkg::*;
#(
    parameter int unsigned WIDTH = NORM_WIDTH,
    parameter int unsigned CNT_W = NORM_CNT_W
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [CNT_W-1:0] c_i,
    input  logic             mode_i,
    output logic             stop_o
);

    logic at_cap;
    logic is_zero;
    logic top_ok;

    assign at_cap  = (c_i == CNT_W'(WIDTH - 1));
    assign is_zero = (r_i == '0);

    always_comb begin
        top_ok = 1'b0;
        if (mode_i == NORM_SIGNED) begin
            // Normalised once the sign bit differs from the bit below it.
            top_ok = r_i[WIDTH-1] ^ r_i[WIDTH-2];
        end else begin
            top_ok = r_i[WIDTH-1];
        end
    end

    assign stop_o = top_ok || is_zero || at_cap;

endmodule

// File: rtl/shift_normalizer.sv
// Multi-cycle normaliser: shifts the operand left one bit per cycle until it is
// normalised and reports the shift amount, with valid/ready on both sides.
module shift_normalizer
    import norm_pkg::*;
#(
    parameter int unsigned WIDTH = NORM_WIDTH,
    parameter int unsigned CNT_W = NORM_CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] OriginB,
    input  logic             NormSigned,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] NormB,
    output logic [CNT_W-1:0] ShiftAmount,
    output logic             IsZero
);

    norm_state_e      state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CNT_W-1:0] c_q, c_d;
    logic             mode_q, mode_d;
    logic             zero_q, zero_d;
    logic             stop;

    norm_stop_detect #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_stop_detect (
        .r_i    (r_q),
        .c_i    (c_q),
        .mode_i (mode_q),
        .stop_o (stop)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            r_q     <= '0;
            c_q     <= '0;
            mode_q  <= NORM_UNSIGNED;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            mode_q  <= mode_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        mode_d  = mode_q;
        zero_d  = zero_q;
        unique case (state_q)
            StIdle: begin
                if (InValid) begin
                    r_d     = OriginB;
                    c_d     = '0;
                    mode_d  = NormSigned;
                    zero_d  = (OriginB == '0);
                    state_d = StShift;
                end
            end
            StShift: begin
                if (stop) begin
                    state_d = StDone;
                end else begin
                    r_d = {r_q[WIDTH-2:0], 1'b0};
                    c_d = c_q + 1'b1;
                end
            end
            StDone: begin
                if (OutReady) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake flags decode straight from the state register, so neither side
    // sees a combinational path from the other.
    assign InReady     = (state_q == StIdle);
    assign OutValid    = (state_q == StDone);
    assign NormB       = r_q;
    assign ShiftAmount = c_q;
    assign IsZero      = zero_q;

endmodule

// File: tb/tb_shift_normalizer.sv
// Scoreboard bench for shift_normalizer: a driver pushes model results, a
// negedge monitor pops and compares them whenever a result is handed off.
module tb_shift_normalizer;

    logic        Clk;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [15:0] OriginB;
    logic        NormSigned;
    logic        OutValid;
    logic        OutReady;
    logic [15:0] NormB;
    logic [3:0]  ShiftAmount;
    logic        IsZero;

    shift_normalizer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .InValid     (InValid),
        .InReady     (InReady),
        .OriginB     (OriginB),
        .NormSigned  (NormSigned),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .NormB       (NormB),
        .ShiftAmount (ShiftAmount),
        .IsZero      (IsZero)
    );

    typedef struct {
        logic [15:0] normb;
        logic [3:0]  amt;
        logic        zero;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    int   cyc       = 0;
    int   ready_mode = 2;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    initial forever begin
        @(posedge Clk);
        #1;
        case (ready_mode)
            0:       OutReady = 1'($urandom_range(0, 1));
            1:       OutReady = 1'b0;
            default: OutReady = 1'b1;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: shift count is the number of leading zeros (unsigned) or
    // redundant sign bits (signed), capped at 15.
    function automatic exp_t model(input logic [15:0] x, input logic s);
        exp_t e;
        int   k;
        int   lead;
        bit   run;
        k = 0;
        if (x != 16'h0) begin
            lead = 0;
            run  = 1'b1;
            for (int i = 15; i >= 0; i--) begin
                if (run && (x[i] == (s ? x[15] : 1'b0))) lead++;
                else run = 1'b0;
            end
            k = s ? lead - 1 : lead;
            if (k > 15) k = 15;
        end
        e.normb = 16'(x << k);
        e.amt   = 4'(k);
        e.zero  = (x == 16'h0);
        e.lat   = k + 1;
        e.acc   = 0;
        return e;
    endfunction

    task automatic send(input logic [15:0] x, input logic s);
        exp_t e;
        int   waits;
        waits = 0;
        @(posedge Clk);
        #1;
        InValid    = 1'b1;
        OriginB    = x;
        NormSigned = s;
        while (!InReady && waits <= 300) begin
            @(posedge Clk);
            #1;
            waits++;
        end
        if (!InReady) begin
            total_cnt++;
            $display("FAIL accept_timeout: InReady stayed 0 for operand 0x%0h", x);
            InValid = 1'b0;
            return;
        end
        e     = model(x, s);
        e.acc = cyc + 1;
        sb_q.push_back(e);
        @(posedge Clk);
        #1;
        InValid    = 1'b0;
        OriginB    = 16'($urandom);
        NormSigned = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0) begin
            @(posedge Clk);
            #1;
            n++;
            if (n > 500) begin
                total_cnt++;
                $display("FAIL drain_timeout: %0d results never appeared", sb_q.size());
                sb_q.delete();
                break;
            end
        end
        repeat (2) @(posedge Clk);
        #1;
    endtask

    // Monitor
    initial begin
        bit          prev_valid;
        bit          prev_stall;
        bit          hs_prev;
        int          first_cyc;
        logic [15:0] last_nb;
        logic [3:0]  last_amt;
        logic        last_zero;
        exp_t        e;
        prev_valid = 0;
        prev_stall = 0;
        hs_prev    = 0;
        first_cyc  = 0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                prev_valid = 0;
                prev_stall = 0;
                hs_prev    = 0;
            end else begin
                if (hs_prev) begin
                    chk("inready_after_handshake", 32'(InReady), 32'd1);
                    chk("outvalid_after_handshake", 32'(OutValid), 32'd0);
                end
                hs_prev = 0;
                if (OutValid) begin
                    chk("inready_while_done", 32'(InReady), 32'd0);
                    if (!prev_valid) first_cyc = cyc;
                    if (prev_stall) begin
                        chk("stall_normb", 32'(NormB), 32'(last_nb));
                        chk("stall_amt", 32'(ShiftAmount), 32'(last_amt));
                        chk("stall_zero", 32'(IsZero), 32'(last_zero));
                    end
                    last_nb    = NormB;
                    last_amt   = ShiftAmount;
                    last_zero  = IsZero;
                    prev_stall = !OutReady;
                    if (OutReady) begin
                        hs_prev = 1;
                        if (sb_q.size() == 0) begin
                            total_cnt++;
                            $display("FAIL unexpected_output: NormB 0x%0h amt %0d, none expected",
                                     NormB, ShiftAmount);
                        end else begin
                            e = sb_q.pop_front();
                            chk("normb", 32'(NormB), 32'(e.normb));
                            chk("shift_amount", 32'(ShiftAmount), 32'(e.amt));
                            chk("is_zero", 32'(IsZero), 32'(e.zero));
                            chk("latency", 32'(first_cyc - e.acc), 32'(e.lat));
                        end
                    end
                end else begin
                    prev_stall = 0;
                end
                prev_valid = OutValid;
            end
        end
    end

    logic [15:0] dir_val [10] = '{16'h0001, 16'h00F0, 16'h8000, 16'h0000, 16'h0000,
                                  16'hFFF0, 16'h0001, 16'hFFFF, 16'h7FFF, 16'hC000};
    logic        dir_sgn [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        int          n;
        logic [15:0] v;
        Reset      = 1'b1;
        InValid    = 1'b0;
        OriginB    = 16'h0;
        NormSigned = 1'b0;
        OutReady   = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_inready", 32'(InReady), 32'd1);
        chk("reset_outvalid", 32'(OutValid), 32'd0);
        chk("reset_normb", 32'(NormB), 32'd0);
        chk("reset_amt", 32'(ShiftAmount), 32'd0);
        chk("reset_zero", 32'(IsZero), 32'd0);
        Reset = 1'b0;

        foreach (dir_val[i]) send(dir_val[i], dir_sgn[i]);
        drain();

        ready_mode = 0;
        for (int i = 0; i < 40; i++) begin
            v = 16'($urandom) >> $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) v = ~v;
            send(v, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(posedge Clk);
        end
        drain();

        // Backpressure: hold the result while garbage is offered on the input.
        ready_mode = 1;
        @(posedge Clk);
        send(16'h00F0, 1'b0);
        n = 0;
        while (!OutValid && n < 40) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk("stall_reached_done", 32'(OutValid), 32'd1);
        repeat (5) begin
            @(posedge Clk);
            #1;
            InValid = 1'b1;
            OriginB = 16'($urandom);
            chk("stall_inready", 32'(InReady), 32'd0);
        end
        InValid    = 1'b0;
        ready_mode = 2;
        drain();

        // Reset mid-operation discards the operand.
        send(16'h0001, 1'b0);
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        sb_q.delete();
        chk("midreset_inready", 32'(InReady), 32'd1);
        chk("midreset_outvalid", 32'(OutValid), 32'd0);
        chk("midreset_normb", 32'(NormB), 32'd0);
        chk("midreset_amt", 32'(ShiftAmount), 32'd0);
        chk("midreset_zero", 32'(IsZero), 32'd0);
        Reset = 1'b0;
        send(16'h00F0, 1'b0);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/shift_normalizer.md
Name: shift_normalizer

Overview:
- Multi-cycle normaliser: the inverse of the datapath barrel shifter. Given a 16-bit operand, it finds the left-shift amount that normalises it and returns that amount with the normalised value.
- Shifts one bit per cycle and uses valid/ready handshakes on both sides.
- Sits beside the barrel shifter in the datapath. Its ShiftAmount output drives the shifter's 4-bit amount input for later denormalisation or realignment.

Parameters:
- WIDTH, 16, operand width in bits.
- CNT_W, 4, shift-count width; equals log2(WIDTH).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  1  OriginB/NormSigned are valid.
- InReady  output  1  block can accept an operand.
- OriginB  input  WIDTH  operand to normalise.
- NormSigned  input  1  0 = unsigned normalisation, 1 = two's-complement normalisation; sampled on accept.
- OutValid  output  1  result is valid.
- OutReady  input  1  consumer accepts the result.
- NormB  output  WIDTH  normalised operand.
- ShiftAmount  output  CNT_W  number of left shifts applied.
- IsZero  output  1  operand was 0.

Behaviour:
- One clock (Clk). Reset is synchronous and active-high: Reset high at a rising edge forces state IDLE, NormB=0, ShiftAmount=0, IsZero=0, OutValid=0. InReady is then 1 (it is a function of state).
- FSM states: IDLE, SHIFT, DONE.
- IDLE: InReady=1, OutValid=0.
  - On InValid&InReady, load a working register from OriginB, clear the count, latch NormSigned, latch IsZero=(OriginB==0), and go to SHIFT.
  - OriginB is not sampled outside IDLE.
- Stop condition, evaluated on the working register R and count C in SHIFT:
  - unsigned mode: R[WIDTH-1]==1, or R==0, or C==WIDTH-1.
  - signed mode: R[WIDTH-1]!=R[WIDTH-2], or R==0, or C==WIDTH-1.
- SHIFT:
  - If the stop condition holds, go to DONE with R and C unchanged.
  - Otherwise R<=R<<1 (zero fill) and C<=C+1.
  - C never exceeds WIDTH-1; no wrap.
- DONE:
  - OutValid=1; NormB=R, ShiftAmount=C, IsZero as latched.
  - All outputs are held stable while OutReady=0.
  - On OutValid&OutReady, go to IDLE. InReady becomes 1 in the following cycle; there is no same-cycle re-accept.
- Latency: operand accepted at edge E0; OutValid is high after edge E(k+1), where k is the final ShiftAmount.
  - Zero operand: k=0, latency 1 cycle.
  - Worst case: 16 cycles.
- Signed all-ones (0xFFFF) stops only on the count cap: NormB=0x8000, ShiftAmount=15.
- Reset mid-operation (SHIFT or DONE) discards the operand. No OutValid pulse is produced for it.
- Simultaneous InValid and a pending result in DONE: the input is not accepted because InReady=0, so the producer must hold it.
- Outputs are registered; there are no combinational paths from InValid to OutValid or from OutReady to InReady.

Decomposition:
- Shared package norm_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - WIDTH/CNT_W defaults;
  - the mode constants NORM_UNSIGNED=0 and NORM_SIGNED=1.
- One sub-module, norm_stop_detect: purely combinational. Inputs R, C, mode; output stop. This keeps the FSM readable and is separately testable.

Test Plan:
- Unsigned 0x0001 -> NormB 0x8000, ShiftAmount 15, IsZero 0, OutValid 16 cycles after accept.
- Unsigned 0x00F0 -> NormB 0xF000, ShiftAmount 8; unsigned 0x8000 -> NormB 0x8000, ShiftAmount 0, latency 1.
- Zero operand, either mode -> NormB 0x0000, ShiftAmount 0, IsZero 1, latency 1.
- Signed cases:
  - 0xFFF0 -> NormB 0x8000, ShiftAmount 11.
  - 0x0001 -> NormB 0x4000, ShiftAmount 14.
  - 0xFFFF -> NormB 0x8000, ShiftAmount 15 (count cap).
- Backpressure: hold OutReady=0 for 5 cycles in DONE -> outputs constant and InReady=0 throughout. Then assert OutReady -> one handshake, InReady=1 on the next cycle. Toggle OriginB during the stall -> result unaffected.
- Reset mid-operation: accept 0x0001, assert Reset at cycle 5 -> next cycle IDLE, InReady=1, OutValid=0, outputs 0. A fresh 0x00F0 then gives ShiftAmount 8.
